axis_bram_adapter_v1_0_s00_axis: RTL and testbench
==================================================

Name: axis_bram_adapter_v1_0_s00_axis

Overview:
AXI4-Stream slave front end for the AXIS-to-BRAM adapter. It accepts 32-bit stream beats on the S_AXIS port and buffers them in a small internal FIFO. It presents the beats in order to the downstream buffer writer through a valid/accept handshake (DOUT_*). TLAST marks a frame end: the block stops accepting input until the buffered frame has fully drained downstream.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream and DOUT data width in bits.
FIFO_DEPTH, 8, number of buffered beats; must be a power of 2 and at least 2.

Ports:
S_AXIS_ACLK  in  1  single clock; all logic on its rising edge.
S_AXIS_ARESETN  in  1  synchronous, active-high reset. Despite the name suffix, 1 means reset.
S_AXIS_TVALID  in  1  upstream beat valid.
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data.
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes; accepted and ignored (all bytes stored).
S_AXIS_TLAST  in  1  last beat of frame.
S_AXIS_TREADY  out  1  block can accept a beat this cycle.
DOUT_TO_BUF  out  C_S_AXIS_TDATA_WIDTH  head-of-FIFO data toward the buffer.
DOUT_VALID  out  1  DOUT_TO_BUF holds a valid beat.
DOUT_ACCEP  in  1  downstream consumes the presented beat.

Behaviour:
- Reset (S_AXIS_ARESETN=1 at a clock edge):
  - FIFO emptied; read/write pointers and count set to 0.
  - State set to RECEIVE.
  - DOUT_VALID=0, DOUT_TO_BUF=0, S_AXIS_TREADY=0 during reset.
  - Reset has priority over every other event, including mid-frame and mid-drain.
- Write: when S_AXIS_TVALID && S_AXIS_TREADY at an edge, store TDATA at the write pointer and increment the write pointer (wraps modulo FIFO_DEPTH). Otherwise TDATA is don't-care.
- Read: when DOUT_VALID && DOUT_ACCEP at an edge, increment the read pointer (wraps).
- DOUT_VALID = (count != 0). DOUT_TO_BUF = FIFO entry at the read pointer when DOUT_VALID, else 0.
- Latency: a beat written at edge N is visible on DOUT after edge N, provided it is the head. Empty FIFO → one-cycle latency from handshake to DOUT_VALID.
- Order is strictly preserved. No beat is dropped or duplicated.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - unchanged when both occur in the same cycle.
- S_AXIS_TREADY depends only on registered state, with no combinational path from DOUT_ACCEP or TVALID:
  - RECEIVE: TREADY = (count != FIFO_DEPTH).
  - DRAIN: TREADY = 0.
- Full: count == FIFO_DEPTH → TREADY=0, even if a read occurs in the same cycle. Input resumes the cycle after count drops.
- Empty: DOUT_VALID=0. DOUT_ACCEP is ignored and has no effect.
- State machine:
  - RECEIVE → DRAIN on an accepted beat with S_AXIS_TLAST=1. That beat is stored normally.
  - DRAIN → RECEIVE at the edge where count becomes 0, i.e. last entry read with no write. TREADY=1 in the following cycle.
  - DRAIN holds while count != 0.
- TLAST on a non-accepted cycle (TVALID=0 or TREADY=0) is ignored.
- X on DOUT_ACCEP while DOUT_VALID=0 has no effect.

Test Plan:
1. Reset held 1 cycle, then released:
   - DOUT_VALID=0 and TREADY=0 during reset.
   - TREADY=1 first cycle after release.
   - DOUT_TO_BUF=0.
2. TVALID=1 with TDATA 0,1,2 on consecutive cycles, DOUT_ACCEP=1:
   - DOUT_TO_BUF shows 0,1,2 one cycle after each acceptance.
   - DOUT_VALID=1 continuously.
   - count never exceeds 1.
3. Continue streaming 3,4 while DOUT_ACCEP=0 for 2 cycles, then 1:
   - head value holds steady and DOUT_VALID stays 1 during the stall.
   - afterwards all values emerge in order with none lost or duplicated.
4. DOUT_ACCEP=0 with TVALID=1 and data 10..19:
   - exactly 8 beats (10..17) accepted, then TREADY=0.
   - after DOUT_ACCEP=1: 10..17 delivered in order.
   - TREADY returns 1 the cycle after the first read.
5. Send 5 with TLAST=1, then hold 6,7 with TVALID=1:
   - TREADY=0 immediately after 5 is accepted.
   - 6 not accepted until 5 is consumed and the FIFO is empty.
   - then 6,7 accepted and delivered.
6. Assert reset while the FIFO holds 3 beats in DRAIN:
   - DOUT_VALID=0 next cycle and old data never appears.
   - TREADY=1 after release.

Source files
------------

// File: rtl/axis_bram_adapter_v1_0_s00_axis.sv
// AXI4-Stream slave front end: buffers incoming beats in a small FIFO and presents
// them in order on a valid/accept port; a TLAST beat blocks input until the frame drains.
module axis_bram_adapter_v1_0_s00_axis #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 8
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     DOUT_TO_BUF,
    output logic                                DOUT_VALID,
    input  logic                                DOUT_ACCEP
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_RECEIVE,
        ST_DRAIN
    } state_t;

    // The reset input is active-high despite its name.
    logic srst;
    assign srst = S_AXIS_ARESETN;

    state_t                          state_reg;
    logic [PTR_W-1:0]                wr_ptr_reg;
    logic [PTR_W-1:0]                rd_ptr_reg;
    logic [CNT_W-1:0]                count_reg;
    logic [CNT_W-1:0]                count_next;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic wr_en;
    logic rd_en;
    logic not_full;
    logic not_empty;

    // Byte strobes carry no information here: every byte is stored.
    logic unused_tstrb;
    assign unused_tstrb = ^S_AXIS_TSTRB;

    assign not_full  = (count_reg != FULL_CNT);
    assign not_empty = (count_reg != '0);

    // Ready comes only from registered state (plus reset masking), never from TVALID or DOUT_ACCEP.
    assign S_AXIS_TREADY = !srst && (state_reg == ST_RECEIVE) && not_full;
    assign DOUT_VALID    = !srst && not_empty;
    assign DOUT_TO_BUF   = DOUT_VALID ? mem[rd_ptr_reg] : '0;

    assign wr_en = S_AXIS_TVALID && S_AXIS_TREADY;
    assign rd_en = DOUT_VALID && DOUT_ACCEP;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= S_AXIS_TDATA;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (srst) begin
            state_reg  <= ST_RECEIVE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case (state_reg)
                ST_RECEIVE: begin
                    if (wr_en && S_AXIS_TLAST) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // No writes happen while draining, so reaching zero means the frame is out.
                    if (count_next == '0) begin
                        state_reg <= ST_RECEIVE;
                    end
                end
                default: state_reg <= ST_RECEIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_s00_axis.sv
// Bench for the AXIS slave FIFO front end: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based frame model.
module tb_axis_bram_adapter_v1_0_s00_axis;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic           clk;
    logic           rst_in;
    logic           tvalid;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic           tready;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           dout_accep;

    axis_bram_adapter_v1_0_s00_axis #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(rst_in),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TVALID (tvalid),
        .DOUT_TO_BUF   (dout),
        .DOUT_VALID    (dout_valid),
        .DOUT_ACCEP    (dout_accep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: beats currently held, and whether a closed frame is draining.
    logic [W-1:0] model_q[$];
    bit           frame_closed = 0;

    task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic rst, input logic tv, input logic [W-1:0] td,
                        input logic tl, input logic acc, output logic accepted);
        logic         exp_tready;
        logic         exp_valid;
        logic [W-1:0] exp_dout;
        logic [W-1:0] popped;
        bit           did_rd;
        bit           did_wr;
        @(negedge clk);
        rst_in     = rst;
        tvalid     = tv;
        tdata      = td;
        tlast      = tl;
        dout_accep = acc;
        #1;
        exp_tready = !rst && !frame_closed && (model_q.size() < DEPTH);
        exp_valid  = !rst && (model_q.size() != 0);
        exp_dout   = exp_valid ? model_q[0] : '0;
        check_value("tready", {31'b0, tready}, {31'b0, exp_tready});
        check_value("dout_valid", {31'b0, dout_valid}, {31'b0, exp_valid});
        check_value("dout", dout, exp_dout);
        accepted = tv && tready;
        @(posedge clk);
        did_rd = 0;
        did_wr = 0;
        popped = '0;
        if (rst) begin
            model_q.delete();
            frame_closed = 0;
        end else begin
            if (exp_valid && acc) begin
                popped = model_q.pop_front();
                did_rd = 1;
            end
            if (tv && exp_tready) begin
                model_q.push_back(td);
                did_wr = 1;
                if (tl) frame_closed = 1;
            end
            if (frame_closed && model_q.size() == 0) frame_closed = 0;
        end
        if (rst)
            $display("t=%0t reset", $time);
        else if (did_wr || did_rd)
            $display("t=%0t wr=%0d data=%08h last=%0d rd=%0d data=%08h held=%0d",
                     $time, did_wr, td, tl, did_rd, popped, model_q.size());
    endtask

    initial begin
        logic         a;
        logic [W-1:0] v;
        int           acc_cnt;

        rst_in     = 1'b1;
        tvalid     = 1'b0;
        tdata      = '0;
        tstrb      = '1;
        tlast      = 1'b0;
        dout_accep = 1'b0;

        // Reset, then release
        step(1, 0, 0, 0, 0, a);
        step(1, 0, 0, 0, 0, a);
        step(0, 0, 0, 0, 0, a);

        // Pass-through streaming
        step(0, 1, 0, 0, 1, a);
        step(0, 1, 1, 0, 1, a);
        step(0, 1, 2, 0, 1, a);

        // Stall downstream while streaming 3,4
        step(0, 1, 3, 0, 0, a);
        step(0, 1, 4, 0, 0, a);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, a);

        // Fill to full with downstream blocked
        v = 10;
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, v, 0, 0, a);
            if (a) begin
                acc_cnt++;
                v++;
            end
        end
        check_value("fill_accepted", acc_cnt, 8);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, a);

        // Frame end blocks input until drained
        step(0, 1, 5, 1, 0, a);
        v = 6;
        for (int i = 0; i < 10; i++) begin
            step(0, (v <= 7), v, 0, (i >= 2), a);
            if (a) v++;
        end
        check_value("post_frame_sent", v, 8);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, a);

        // Reset during drain with three beats held
        step(0, 1, 20, 0, 0, a);
        step(0, 1, 21, 0, 0, a);
        step(0, 1, 22, 1, 0, a);
        step(0, 1, 23, 0, 0, a);
        step(1, 1, 24, 0, 1, a);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, a);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 128) == 0, ($urandom % 4) != 0, $urandom,
                 ($urandom % 8) == 0, ($urandom % 3) != 0, a);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
